// File: rtl/swarm_param_responder.sv
// swarm_param_responder: AXI4-Lite slave exposing build parameters, a host scratch
// register, a logging-enable mask and a free-running cycle counter.
//
// Ports:
//   clk, rst                        single clock, synchronous active-high reset
//   aw*/w*/b*                       write address / data / response channels
//   ar*/r*                          read address / data channels
//   log_en                          host-controlled logging-enable mask
//   scratch                         host scratch register
//
// Map (addr[7:2] decoded): 0x00-0x14 RO parameters, 0x20 scratch (RW),
// 0x24 log_en (RW, [7:0]), 0x28 cycle counter (RO). Unmapped -> SLVERR.
//
// Build option: define SWARM_PARAM_RESP_WRITE_EN to include the writable registers.
// Without it every write completes with SLVERR and log_en/scratch stay 0.
module swarm_param_responder #(
  parameter int unsigned VERSION           = 10,
  parameter int unsigned N_TILES           = 1,
  parameter int unsigned TS_WIDTH          = 32,
  parameter int unsigned LOG_TQ_SIZE       = 12,
  parameter int unsigned LOG_CQ_SLICE_SIZE = 7,
  parameter logic [2:0]  FLAGS             = 3'b010
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        awvalid,
  output logic        awready,
  input  logic [7:0]  awaddr,
  input  logic        wvalid,
  output logic        wready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic        bvalid,
  input  logic        bready,
  output logic [1:0]  bresp,
  input  logic        arvalid,
  output logic        arready,
  input  logic [7:0]  araddr,
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic [7:0]  log_en,
  output logic [31:0] scratch
);

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  typedef enum logic [1:0] {StIdle, StWData, StBResp, StRResp} state_e;

  state_e      state_q, state_d;
  logic [5:0]  waddr_q;
  logic [31:0] rdata_q, cycle_q, scratch_q;
  logic [7:0]  log_en_q;
  logic [1:0]  rresp_q, bresp_q;

  logic        ar_hs, aw_only, wr_do, wr_ok;
  logic [5:0]  wr_idx;
  logic [31:0] rd_data;
  logic        rd_err;

  // Handshake / next-state logic. Reset overrides everything so no ready is
  // advertised and no transaction is accepted while rst is high.
  always_comb begin
    state_d = state_q;
    awready = 1'b0;
    arready = 1'b0;
    wready  = 1'b0;
    ar_hs   = 1'b0;
    aw_only = 1'b0;
    wr_do   = 1'b0;
    wr_idx  = waddr_q;
    case (state_q)
      StIdle: begin
        arready = 1'b1;
        // Reads win: a pending AR blocks AW/W for this cycle.
        awready = !arvalid;
        wready  = awvalid && !arvalid;
        if (arvalid) begin
          ar_hs   = 1'b1;
          state_d = StRResp;
        end else if (awvalid) begin
          wr_idx = awaddr[7:2];
          if (wvalid) begin
            wr_do   = 1'b1;
            state_d = StBResp;
          end else begin
            aw_only = 1'b1;
            state_d = StWData;
          end
        end
      end
      StWData: begin
        wready = 1'b1;
        if (wvalid) begin
          wr_do   = 1'b1;
          state_d = StBResp;
        end
      end
      StBResp: if (bready) state_d = StIdle;
      StRResp: if (rready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (rst) begin
      awready = 1'b0;
      arready = 1'b0;
      wready  = 1'b0;
      ar_hs   = 1'b0;
      aw_only = 1'b0;
      wr_do   = 1'b0;
      state_d = StIdle;
    end
  end

  // Read decode from the live AR address; captured at the AR handshake.
  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    case (araddr[7:2])
      6'd0:    rd_data = 32'(VERSION);
      6'd1:    rd_data = 32'(N_TILES);
      6'd2:    rd_data = 32'(TS_WIDTH);
      6'd3:    rd_data = 32'(LOG_TQ_SIZE);
      6'd4:    rd_data = 32'(LOG_CQ_SLICE_SIZE);
      6'd5:    rd_data = {29'd0, FLAGS};
      6'd8:    rd_data = scratch_q;
      6'd9:    rd_data = {24'd0, log_en_q};
      6'd10:   rd_data = cycle_q;
      default: rd_err  = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      waddr_q <= '0;
      rdata_q <= '0;
      rresp_q <= RespOkay;
      bresp_q <= RespOkay;
      cycle_q <= '0;
    end else begin
      state_q <= state_d;
      cycle_q <= cycle_q + 32'd1;
      if (ar_hs) begin
        rdata_q <= rd_data;
        rresp_q <= rd_err ? RespSlvErr : RespOkay;
      end
      if (aw_only) waddr_q <= awaddr[7:2];
      if (wr_do)   bresp_q <= wr_ok ? RespOkay : RespSlvErr;
    end
  end

`ifdef SWARM_PARAM_RESP_WRITE_EN
  assign wr_ok = (wr_idx == 6'd8) || (wr_idx == 6'd9);

  always_ff @(posedge clk) begin
    if (rst) begin
      scratch_q <= '0;
      log_en_q  <= '0;
    end else if (wr_do && wr_ok) begin
      if (wr_idx == 6'd8) begin
        for (int b = 0; b < 4; b++) begin
          if (wstrb[b]) scratch_q[8*b +: 8] <= wdata[8*b +: 8];
        end
      end else if (wstrb[0]) begin
        log_en_q <= wdata[7:0];
      end
    end
  end

  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{awaddr[1:0], araddr[1:0]};
`else
  assign wr_ok     = 1'b0;
  assign scratch_q = '0;
  assign log_en_q  = '0;

  logic unused_write_path;
  assign unused_write_path = ^{awaddr[1:0], araddr[1:0], wdata, wstrb, wr_idx};
`endif

  assign bvalid  = (state_q == StBResp) && !rst;
  assign rvalid  = (state_q == StRResp) && !rst;
  assign bresp   = bresp_q;
  assign rresp   = rresp_q;
  assign rdata   = rdata_q;
  assign log_en  = log_en_q;
  assign scratch = scratch_q;

endmodule

// File: doc/swarm_param_responder.md
SWARM_PARAM_RESPONDER -- requirements
Module: swarm_param_responder

Interface
REQ-001 SHALL have parameter VERSION, default 10, the address-map version returned at offset 0x00.
REQ-002 SHALL have parameter N_TILES, default 1, the tile count returned at offset 0x04.
REQ-003 SHALL have parameter TS_WIDTH, default 32, the timestamp width returned at offset 0x08.
REQ-004 SHALL have parameter LOG_TQ_SIZE, default 12, returned at offset 0x0C.
REQ-005 SHALL have parameter LOG_CQ_SLICE_SIZE, default 7, returned at offset 0x10.
REQ-006 SHALL have parameter FLAGS, default 3'b010, holding {UNORDERED, NON_SPEC, NO_SPILLING} and returned in bits [2:0] at offset 0x14.
REQ-007 SHALL have port clk, input, 1 bit: the single clock.
REQ-008 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-009 SHALL have ports awvalid (in, 1), awready (out, 1) and awaddr (in, 8): the write-address channel.
REQ-010 SHALL have ports wvalid (in, 1), wready (out, 1), wdata (in, 32) and wstrb (in, 4): the write-data channel.
REQ-011 SHALL have ports bvalid (out, 1), bready (in, 1) and bresp (out, 2): the write-response channel.
REQ-012 SHALL have ports arvalid (in, 1), arready (out, 1) and araddr (in, 8): the read-address channel.
REQ-013 SHALL have ports rvalid (out, 1), rready (in, 1), rdata (out, 32) and rresp (out, 2): the read-data channel.
REQ-014 SHALL have port log_en, output, 8 bits: the host-controlled logging-enable mask.
REQ-015 SHALL have port scratch, output, 32 bits: the host scratch register.

Function
REQ-016 SHALL implement states IDLE, W_DATA, B_RESP and R_RESP, with at most one transaction outstanding.
REQ-017 SHALL, in IDLE, drive arready=1 and awready=1, and drive wready=1 only when awvalid=1.
REQ-018 SHALL give the read channel priority: if arvalid=1 in IDLE, it accepts only AR that cycle (awready=wready=0), and the state moves to R_RESP.
REQ-019 SHALL, in R_RESP, drive rvalid=1 with rdata and rresp registered at the AR handshake, hold them stable until rready=1, then return to IDLE.
REQ-020 SHALL, when AW and W handshake in the same cycle, perform the write and go to B_RESP; when AW alone handshakes, latch awaddr and go to W_DATA with wready=1.
REQ-021 SHALL, in B_RESP, drive bvalid=1 and hold bresp until bready=1, then return to IDLE.
REQ-022 SHALL decode address bits [7:2] only; bits [1:0] are ignored.
REQ-023 SHALL map the registers as follows: 0x00-0x14 read-only parameters (zero-extended to 32 bits); 0x20 scratch (RW); 0x24 log_en (RW, bits [7:0], upper bits read 0); 0x28 cycle counter (RO).
REQ-024 SHALL read the cycle counter as a free-running 32-bit counter that increments every cycle, wraps from 0xFFFFFFFF to 0, and is sampled in the AR-handshake cycle.
REQ-025 SHALL apply writes per byte under wstrb; wstrb=0 completes with OKAY and changes nothing.
REQ-026 SHALL return rresp/bresp OKAY (2'b00) for mapped accesses and SLVERR (2'b10) for writes to RO offsets or to unmapped offsets, with no state change.
REQ-027 SHALL return SLVERR with rdata=0 for reads of unmapped offsets.
REQ-028 SHALL make a write visible on log_en/scratch in the cycle after the W handshake; a read to the same register issued afterward returns the new value.

Reset
REQ-029 SHALL, while rst=1, force state IDLE, awready=arready=wready=0, bvalid=rvalid=0, bresp=rresp=0, rdata=0, log_en=0, scratch=0 and counter=0.
REQ-030 SHALL abandon any in-flight transaction when rst asserts mid-transaction, with no response issued; awready and arready are 1 in the first cycle after rst deasserts.

Configuration
REQ-031 SHALL include the writable registers when macro SWARM_PARAM_RESP_WRITE_EN is defined, with behaviour as above.
REQ-032 SHALL, when SWARM_PARAM_RESP_WRITE_EN is undefined, complete every write handshake with SLVERR and hold log_en and scratch at 0; reads are unchanged.

Verification
REQ-033 SHALL cover: after reset, AR 0x00 -> rdata=10, rresp=00, rvalid one cycle after the AR handshake.
REQ-034 SHALL cover: AW 0x20 plus W 0xA5A5A5A5 with wstrb=4'b0011 in the same cycle, after scratch=0x12345678 -> bresp=00, scratch=0x1234A5A5, and AR 0x20 returns 0x1234A5A5.
REQ-035 SHALL cover: AW 0x24, then W 0x000000FF with wstrb=F three cycles later -> wready high only in W_DATA, log_en=0xFF, bvalid asserted the cycle after the W handshake.
REQ-036 SHALL cover: arvalid and awvalid/wvalid asserted together in IDLE -> read served first (awready=0 that cycle), then the write completes after rready.
REQ-037 SHALL cover: AR 0x3C -> rdata=0, rresp=10; AW/W to 0x04 -> bresp=10 and the register still reads N_TILES.
REQ-038 SHALL cover: rready held low 5 cycles during R_RESP, then rst pulsed -> rvalid=0 the next cycle, counter reads small after reset, and no stale response is issued.
